bw_muldiv_unit: RTL and testbench

- Parametrised, multi-cycle integer multiply/divide unit for the BlackWidow execute stage.
- Sits beside the single-cycle combinational ALU and takes the R2 MUL/DIV/REM family that the ALU returns as zero.
- Iterative radix-2 datapath: shift-add for multiply, restoring for divide. Width is generic.
- Valid/ready handshake on both request and result sides, with a flush input for pipeline redirect.

---
 rtl/rfBlackWidowPkg.sv | 53 +++++
 rtl/bw_muldiv_abs.sv | 13 +
 rtl/bw_muldiv_unit.sv | 196 +++++++++++++++++++
 tb/tb_bw_muldiv_unit.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/rfBlackWidowPkg.sv
// BlackWidow shared definitions: mul/div operation codes, FSM states and R2 func-code mapping.
package rfBlackWidowPkg;

  typedef enum logic [2:0] {
    OP_MUL   = 3'd0,
    OP_MULU  = 3'd1,
    OP_MULH  = 3'd2,
    OP_MULHU = 3'd3,
    OP_DIV   = 3'd4,
    OP_DIVU  = 3'd5,
    OP_REM   = 3'd6,
    OP_REMU  = 3'd7
  } muldiv_op_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIXUP,
    S_DONE
  } muldiv_state_t;

  // R2 func codes; the low three bits line up with muldiv_op_t
  localparam logic [5:0] R2_MUL   = 6'h18;
  localparam logic [5:0] R2_MULU  = 6'h19;
  localparam logic [5:0] R2_MULH  = 6'h1A;
  localparam logic [5:0] R2_MULHU = 6'h1B;
  localparam logic [5:0] R2_DIV   = 6'h1C;
  localparam logic [5:0] R2_DIVU  = 6'h1D;
  localparam logic [5:0] R2_REM   = 6'h1E;
  localparam logic [5:0] R2_REMU  = 6'h1F;

  function automatic muldiv_op_t r2_to_muldiv_op(input logic [5:0] func);
    return muldiv_op_t'(func[2:0]);
  endfunction

  function automatic logic is_signed_op(input muldiv_op_t o);
    return ~o[0];
  endfunction

  function automatic logic is_div_op(input muldiv_op_t o);
    return o[2];
  endfunction

  function automatic logic is_rem_op(input muldiv_op_t o);
    return o[2] & o[1];
  endfunction

  function automatic logic is_mulh_op(input muldiv_op_t o);
    return ~o[2] & o[1];
  endfunction

endpackage

// File: rtl/bw_muldiv_abs.sv
// Conditional two's-complement negation, used for operand magnitude and result sign fixup.
// Purely combinational; no handshake.
module bw_muldiv_abs #(
  parameter int WID = 80
) (
  input  logic [WID-1:0] val_i,
  input  logic           neg_i,
  output logic [WID-1:0] val_o
);

  assign val_o = neg_i ? -val_i : val_i;

endmodule

// File: rtl/bw_muldiv_unit.sv
// Iterative radix-2 multiply (shift-add) / divide (restoring) unit with valid/ready on both sides.
// Result valid WID+1 edges after the accept edge; req_ready only in IDLE, result held until res_ready.
module bw_muldiv_unit
  import rfBlackWidowPkg::*;
#(
  parameter int WID  = 80,
  parameter int TAGW = 8,
  parameter int CNTW = $clog2(WID+1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      op,
  input  logic [WID-1:0]  a,
  input  logic [WID-1:0]  b,
  input  logic [TAGW-1:0] tag_i,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [WID-1:0]  res,
  output logic [TAGW-1:0] tag_o,
  output logic            dbz
);

  muldiv_state_t   state_q, state_d;
  logic [CNTW-1:0] count_q, count_d;
  muldiv_op_t      op_q, op_d;
  logic [TAGW-1:0] tag_q, tag_d;
  logic            sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic            bzero_q, bzero_d;
  logic [2*WID-1:0] acc_q, acc_d;
  logic [WID-1:0]  opnd_q, opnd_d;
  logic [WID-1:0]  rem_q, rem_d;
  logic [WID-1:0]  res_q, res_d;
  logic [TAGW-1:0] tag_o_q, tag_o_d;
  logic            dbz_q, dbz_d;
  logic            res_valid_q, res_valid_d;

  muldiv_op_t     op_in;
  logic           sign_a_in, sign_b_in;
  logic [WID-1:0] a_mag, b_mag;

  assign op_in     = muldiv_op_t'(op);
  assign sign_a_in = is_signed_op(op_in) & a[WID-1];
  assign sign_b_in = is_signed_op(op_in) & b[WID-1];

  bw_muldiv_abs #(.WID(WID)) u_abs_a (.val_i(a), .neg_i(sign_a_in), .val_o(a_mag));
  bw_muldiv_abs #(.WID(WID)) u_abs_b (.val_i(b), .neg_i(sign_b_in), .val_o(b_mag));

  // Multiply step: add multiplicand into the high half when the current multiplier bit is set, then shift right
  logic [WID:0]     mul_sum;
  logic [2*WID-1:0] mul_next;
  assign mul_sum  = {1'b0, acc_q[2*WID-1:WID]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next = {mul_sum, acc_q[WID-1:1]};

  // Divide step: the WID+1 bit partial remainder is compared against the divisor
  logic [WID:0]   div_shift;
  logic [WID-1:0] div_diff;
  logic           div_ge;
  assign div_shift = {rem_q, acc_q[WID-1]};
  assign div_ge    = div_shift >= {1'b0, opnd_q};
  assign div_diff  = div_shift[WID-1:0] - opnd_q;

  logic [2*WID-1:0] fix_in, fix_out;
  logic             fix_neg;
  logic [WID-1:0]   fix_res;

  always_comb begin
    fix_in  = acc_q;
    fix_neg = sign_a_q ^ sign_b_q;
    if (is_rem_op(op_q)) begin
      fix_in  = {{WID{1'b0}}, rem_q};
      fix_neg = sign_a_q;
    end else if (is_div_op(op_q)) begin
      fix_in  = {{WID{1'b0}}, acc_q[WID-1:0]};
    end
  end

  bw_muldiv_abs #(.WID(2*WID)) u_abs_fix (.val_i(fix_in), .neg_i(fix_neg), .val_o(fix_out));

  always_comb begin
    fix_res = fix_out[WID-1:0];
    if (is_mulh_op(op_q)) begin
      fix_res = fix_out[2*WID-1:WID];
    end else if (is_div_op(op_q) && !is_rem_op(op_q) && bzero_q) begin
      fix_res = '1;
    end
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    op_d        = op_q;
    tag_d       = tag_q;
    sign_a_d    = sign_a_q;
    sign_b_d    = sign_b_q;
    bzero_d     = bzero_q;
    acc_d       = acc_q;
    opnd_d      = opnd_q;
    rem_d       = rem_q;
    res_d       = res_q;
    tag_o_d     = tag_o_q;
    dbz_d       = dbz_q;
    res_valid_d = res_valid_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid && !flush) begin
          op_d     = op_in;
          tag_d    = tag_i;
          sign_a_d = sign_a_in;
          sign_b_d = sign_b_in;
          bzero_d  = (b == '0);
          // Low half of acc holds the multiplier or the dividend; opnd holds the multiplicand or divisor
          acc_d    = {{WID{1'b0}}, is_div_op(op_in) ? a_mag : b_mag};
          opnd_d   = is_div_op(op_in) ? b_mag : a_mag;
          rem_d    = '0;
          count_d  = CNTW'(WID);
          state_d  = is_div_op(op_in) ? S_DIV : S_MUL;
        end
      end
      S_MUL: begin
        acc_d   = mul_next;
        count_d = count_q - CNTW'(1);
        if (count_q == CNTW'(1)) state_d = S_FIXUP;
      end
      S_DIV: begin
        rem_d   = div_ge ? div_diff : div_shift[WID-1:0];
        acc_d   = {acc_q[2*WID-1:WID], acc_q[WID-2:0], div_ge};
        count_d = count_q - CNTW'(1);
        if (count_q == CNTW'(1)) state_d = S_FIXUP;
      end
      S_FIXUP: begin
        res_d       = fix_res;
        tag_o_d     = tag_q;
        dbz_d       = is_div_op(op_q) & bzero_q;
        res_valid_d = 1'b1;
        state_d     = S_DONE;
      end
      S_DONE: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d     = S_IDLE;
      count_d     = '0;
      res_valid_d = 1'b0;
      dbz_d       = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      op_q        <= OP_MUL;
      tag_q       <= '0;
      sign_a_q    <= 1'b0;
      sign_b_q    <= 1'b0;
      bzero_q     <= 1'b0;
      acc_q       <= '0;
      opnd_q      <= '0;
      rem_q       <= '0;
      res_q       <= '0;
      tag_o_q     <= '0;
      dbz_q       <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      op_q        <= op_d;
      tag_q       <= tag_d;
      sign_a_q    <= sign_a_d;
      sign_b_q    <= sign_b_d;
      bzero_q     <= bzero_d;
      acc_q       <= acc_d;
      opnd_q      <= opnd_d;
      rem_q       <= rem_d;
      res_q       <= res_d;
      tag_o_q     <= tag_o_d;
      dbz_q       <= dbz_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign res_valid = res_valid_q;
  assign res       = res_q;
  assign tag_o     = tag_o_q;
  assign dbz       = dbz_q;

endmodule

// File: tb/tb_bw_muldiv_unit.sv
// Scoreboard bench for bw_muldiv_unit at WID=16: expected results queued at issue, popped on result handshake.
module tb_bw_muldiv_unit;

  localparam int WID  = 16;
  localparam int TAGW = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            flush = 1'b0;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic [2:0]      op = 3'd0;
  logic [WID-1:0]  a = '0;
  logic [WID-1:0]  b = '0;
  logic [TAGW-1:0] tag_i = '0;
  logic            res_valid;
  logic            res_ready = 1'b1;
  logic [WID-1:0]  res;
  logic [TAGW-1:0] tag_o;
  logic            dbz;

  bw_muldiv_unit #(.WID(WID), .TAGW(TAGW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .op(op), .a(a), .b(b), .tag_i(tag_i),
    .res_valid(res_valid), .res_ready(res_ready),
    .res(res), .tag_o(tag_o), .dbz(dbz)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WID-1:0]  res;
    logic            dbz;
    logic [TAGW-1:0] tag;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] model(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y);
    longint sx, sy, ux, uy, p;
    logic [31:0] pw;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'(x);
    uy = longint'(y);
    p  = 0;
    case (o)
      3'd0, 3'd1: p = ux * uy;
      3'd2: begin p = sx * sy; pw = p[31:0]; return pw[31:16]; end
      3'd3: begin p = ux * uy; pw = p[31:0]; return pw[31:16]; end
      3'd4: begin
        if (y == 16'h0) return 16'hFFFF;
        if (x == 16'h8000 && y == 16'hFFFF) return 16'h8000;
        p = sx / sy;
      end
      3'd5: begin
        if (y == 16'h0) return 16'hFFFF;
        p = ux / uy;
      end
      3'd6: begin
        if (y == 16'h0) return x;
        if (x == 16'h8000 && y == 16'hFFFF) return 16'h0000;
        p = sx % sy;
      end
      default: begin
        if (y == 16'h0) return x;
        p = ux % uy;
      end
    endcase
    pw = p[31:0];
    return pw[15:0];
  endfunction

  // Result side of the scoreboard: every completed handshake must match the oldest queued expectation
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      chk("result_expected", sbq.size() > 0, 1);
      if (sbq.size() > 0) begin
        exp_t e;
        e = sbq.pop_front();
        chk("res", res, e.res);
        chk("dbz", dbz, e.dbz);
        chk("tag_o", tag_o, e.tag);
      end
    end
  end

  task automatic start_op(input logic [2:0] o, input logic [15:0] ia, input logic [15:0] ib, input logic [7:0] t);
    @(negedge clk);
    req_valid = 1'b1;
    op = o; a = ia; b = ib; tag_i = t;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic issue(input logic [2:0] o, input logic [15:0] ia, input logic [15:0] ib, input logic [7:0] t,
                       input logic [15:0] er, input logic ed, input int hold);
    exp_t e;
    int edges;
    logic [15:0] snap;
    logic stable;
    e.res = er; e.dbz = ed; e.tag = t;
    sbq.push_back(e);
    res_ready = (hold == 0);
    start_op(o, ia, ib, t);
    chk("busy_after_accept", req_ready, 0);
    edges = 1;  // the accept edge itself
    while (!res_valid && edges < 100) begin
      @(posedge clk);
      #1;
      edges++;
    end
    chk("latency", edges, WID + 2);
    if (hold > 0) begin
      snap = res;
      stable = 1'b1;
      repeat (hold) begin
        @(posedge clk);
        #1;
        if (res !== snap || res_valid !== 1'b1 || req_ready !== 1'b0) stable = 1'b0;
      end
      chk("hold_stable", stable, 1);
      res_ready = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  ro;
    logic [15:0] ra, rb;
    logic [7:0]  rt;
    logic        seen;
    int          waited;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_res", res, 0);
    chk("rst_tag_o", tag_o, 0);
    chk("rst_dbz", dbz, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_req_ready", req_ready, 1);

    issue(3'd1, 16'h00FF, 16'h0101, 8'h5A, 16'hFFFF, 1'b0, 0);
    issue(3'd3, 16'h00FF, 16'h0101, 8'h5B, 16'h0000, 1'b0, 0);
    issue(3'd4, 16'hFFF9, 16'h0002, 8'h01, 16'hFFFD, 1'b0, 0);
    issue(3'd6, 16'hFFF9, 16'h0002, 8'h02, 16'hFFFF, 1'b0, 0);
    issue(3'd5, 16'd100,  16'd7,    8'h03, 16'd14,   1'b0, 0);
    issue(3'd7, 16'd100,  16'd7,    8'h04, 16'd2,    1'b0, 0);
    issue(3'd5, 16'h1234, 16'h0000, 8'h05, 16'hFFFF, 1'b1, 0);
    issue(3'd6, 16'h8005, 16'h0000, 8'h06, 16'h8005, 1'b1, 0);
    issue(3'd4, 16'h8000, 16'hFFFF, 8'h07, 16'h8000, 1'b0, 0);
    issue(3'd2, 16'h8000, 16'h8000, 8'h08, 16'h4000, 1'b0, 0);

    for (int i = 0; i < 16; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = 16'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      rt = 8'($urandom);
      issue(ro, ra, rb, rt, model(ro, ra, rb), ro[2] && (rb == 16'h0), 0);
    end

    issue(3'd5, 16'd100, 16'd7, 8'hB0, 16'd14, 1'b0, 10);

    // Flush in the middle of a divide when the iteration counter reads 5
    start_op(3'd5, 16'd1000, 16'd3, 8'hF0);
    repeat (11) @(posedge clk);
    #1;
    chk("busy_before_flush", req_ready, 0);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_to_idle", req_ready, 1);
    seen = 1'b0;
    repeat (25) begin @(posedge clk); #1; if (res_valid) seen = 1'b1; end
    chk("flush_no_result", seen, 0);

    @(negedge clk);
    req_valid = 1'b1; flush = 1'b1;
    op = 3'd1; a = 16'd9; b = 16'd9; tag_i = 8'hF1;
    @(posedge clk);
    #1;
    req_valid = 1'b0; flush = 1'b0;
    chk("flush_blocks_accept", req_ready, 1);
    seen = 1'b0;
    repeat (25) begin @(posedge clk); #1; if (res_valid) seen = 1'b1; end
    chk("flush_idle_no_result", seen, 0);

    start_op(3'd1, 16'd1234, 16'd77, 8'hF2);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_res_valid", res_valid, 0);
    chk("arst_req_ready", req_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_res", res, 0);
    chk("post_rst_tag_o", tag_o, 0);
    chk("post_rst_dbz", dbz, 0);
    chk("post_rst_res_valid", res_valid, 0);
    chk("post_rst_req_ready", req_ready, 1);

    issue(3'd1, 16'd3, 16'd5, 8'h33, 16'd15, 1'b0, 0);

    waited = 0;
    while (sbq.size() != 0 && waited < 50) begin @(posedge clk); waited++; end
    chk("scoreboard_drained", sbq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
